// File: rtl/dt_pack.sv
// Packs a 128x128 8-bit distance map into a 1-bit-per-pixel image, 16 pixels per word.
// Optional build macro DT_BORDER_CLR_EN forces every pixel on the image border to 0.
module dt_pack #(
  parameter logic [7:0] THRESH = 8'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        res_rd,
  output logic [13:0] res_addr,
  input  logic [7:0]  res_di,
  output logic        pk_wr,
  output logic [9:0]  pk_addr,
  output logic [15:0] pk_do
);

`ifdef DT_BORDER_CLR_EN
  localparam bit BorderClr = 1'b1;
`else
  localparam bit BorderClr = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t      state_q, state_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        rd_q, rd_d;
  logic [13:0] addr_q, addr_d;
  logic        wr_q, wr_d;
  logic [9:0]  pka_q, pka_d;
  logic [15:0] pkd_q, pkd_d;
  logic [14:0] sh_q, sh_d;
  logic        b;

  // Pixel bit for the address currently on res_addr (its data is on res_di this cycle).
  function automatic logic pix_bit(input logic [7:0] di, input logic [13:0] idx);
    logic edge_px;
    edge_px = (idx[13:7] == 7'd0) || (idx[13:7] == 7'd127) ||
              (idx[6:0] == 7'd0) || (idx[6:0] == 7'd127);
    return (di >= THRESH) && !(BorderClr && edge_px);
  endfunction

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    rd_d    = rd_q;
    addr_d  = addr_q;
    wr_d    = 1'b0;
    pka_d   = pka_q;
    pkd_d   = pkd_q;
    sh_d    = sh_q;
    b       = 1'b0;

    // Capture stage: a read issued last edge returns its data at this edge.
    if (rd_q) begin
      b    = pix_bit(res_di, addr_q);
      sh_d = {sh_q[13:0], b};
      if (addr_q[3:0] == 4'hF) begin
        wr_d  = 1'b1;
        pkd_d = {sh_q, b};
        pka_d = addr_q[13:4];
      end
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          rd_d    = 1'b1;
          addr_d  = 14'd0;
          busy_d  = 1'b1;
          state_d = READ;
        end
      end
      READ: begin
        if (addr_q == 14'h3FFF) begin
          rd_d    = 1'b0;
          state_d = DRAIN;
        end else begin
          addr_d = addr_q + 14'd1;
        end
      end
      DRAIN: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_q    <= 1'b0;
      addr_q  <= 14'd0;
      wr_q    <= 1'b0;
      pka_q   <= 10'd0;
      pkd_q   <= 16'd0;
      sh_q    <= 15'd0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      pka_q   <= pka_d;
      pkd_q   <= pkd_d;
      sh_q    <= sh_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign res_rd   = rd_q;
  assign res_addr = addr_q;
  assign pk_wr    = wr_q;
  assign pk_addr  = pka_q;
  assign pk_do    = pkd_q;

endmodule

// File: doc/dt_pack.md
DT_PACK -- requirements
Module: dt_pack

Interface
REQ-001 SHALL have parameter: THRESH, default 8'd1, minimum distance value packed as a 1 bit.
REQ-002 SHALL have port: clk  input  1  clock; all state changes on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: start  input  1  one-cycle request to pack the 128x128 distance map.
REQ-005 SHALL have port: busy  output  1  high from start acceptance until done.
REQ-006 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-007 SHALL have port: res_rd  output  1  distance-map RAM read enable.
REQ-008 SHALL have port: res_addr  output  14  pixel address {row[6:0], col[6:0]}.
REQ-009 SHALL have port: res_di  input  8  read data, valid at the rising edge after res_rd/res_addr are registered.
REQ-010 SHALL have port: pk_wr  output  1  packed-image write strobe, one cycle per word.
REQ-011 SHALL have port: pk_addr  output  10  packed word address {row[6:0], col[6:4]}.
REQ-012 SHALL have port: pk_do  output  16  packed word; pixel col[3:0]=k at bit 15-k.

Function
REQ-013 SHALL implement states IDLE, READ, DRAIN, DONE.
REQ-014 SHALL, in IDLE with start=1, register res_rd=1, res_addr=0, busy=1 and enter READ.
REQ-015 SHALL ignore start in every state other than IDLE, with no restart and no effect on the scan.
REQ-016 SHALL, in READ, increment res_addr by 1 each cycle, reaching 16383, then register res_rd=0 and enter DRAIN.
REQ-017 SHALL, on each edge after an address is issued, capture res_di for that address as bit b = (res_di >= THRESH), unsigned 8-bit compare.
REQ-018 SHALL shift b into a 15-bit shift register (first pixel ends at MSB). When the captured pixel has col[3:0]=15, it SHALL register pk_do = {shreg, b}, pk_addr = pixel index[13:4] and pk_wr=1 for exactly one cycle.
REQ-019 SHALL hold pk_wr=0 on all other cycles. pk_do and pk_addr SHALL hold their last values while pk_wr=0.
REQ-020 SHALL make the first write on the 16th edge after start acceptance, with pk_addr=0.
REQ-021 SHALL, in DRAIN, capture pixel 16383, write word 1023, then enter DONE.
REQ-022 SHALL, in DONE, register done=1 and busy=0 for one cycle, then return to IDLE with done=0.
REQ-023 SHALL issue exactly 16384 reads and 1024 writes per run, in strictly increasing address order with no gaps.
REQ-024 SHALL treat THRESH=0 as every pixel 1 (pk_do=16'hFFFF). THRESH=255 SHALL pack only pixels equal to 255.

Reset
REQ-025 SHALL, on reset low, asynchronously force: state=IDLE; busy, done, res_rd, pk_wr = 0; res_addr, pk_addr, pk_do = 0; shift register = 0.
REQ-026 SHALL, if reset is asserted mid-scan, abort the scan with no further reads or writes. The next start SHALL begin again at address 0.

Configuration
REQ-027 SHALL support macro DT_BORDER_CLR_EN.
REQ-028 SHALL, when DT_BORDER_CLR_EN is defined, force b=0 for row 0, row 127, col 0 and col 127, regardless of res_di.
REQ-029 SHALL, when DT_BORDER_CLR_EN is undefined, apply REQ-017 to every pixel. Timing SHALL be identical in both builds.

Verification
REQ-030 SHALL cover: all res_di=0, THRESH=1 -> 1024 writes of 16'h0000, pk_addr 0..1023, done pulse once, busy low after.
REQ-031 SHALL cover: res_di=8'd3 everywhere, macro undefined -> all words 16'hFFFF. With the macro defined -> words {r,0} = 16'h7FFF, words {r,7} = 16'hFFFE, rows 0 and 127 all 16'h0000.
REQ-032 SHALL cover: only pixel (row 5, col 17) = 1 -> only pk_addr 41 = 16'h4000, all other words 0. First pk_wr exactly 16 cycles after start acceptance.
REQ-033 SHALL cover: THRESH=8'd10 with pixel values 9 and 10 alternating -> every word 16'h5555.
REQ-034 SHALL cover: start pulsed again at read 5000 -> ignored, total still 16384 reads and 1024 writes. A start held high through DONE -> a new run starts only from IDLE.
REQ-035 SHALL cover: reset asserted after word 200 -> all outputs 0 immediately. A new start -> first write pk_addr=0.
